// File: rtl/multicycle_control.sv
// Purpose: multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) driving datapath strobes.
// Latency: R/I-type 4 cycles, LW 4+mem wait, SW 3+mem wait, BEQ 3, J 2, MUL/DIV 3+MULDIV_LAT.
// Backpressure: holds imem_req/dmem_req until ready; MEM_TIMEOUT missing-ready cycles raise bus_err.
module multicycle_control #(
    parameter int ALUOP_W       = 4,
    parameter int MULDIV_LAT    = 4,
    parameter int ENABLE_MULDIV = 1,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               ir_load,
    output logic               pc_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_start,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               illegal,
    output logic               bus_err,
    output logic               busy
);
    typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
    typedef enum logic [3:0] {K_RALU, K_SHIFT, K_IMM, K_LW, K_SW, K_BEQ, K_J, K_MULDIV, K_ILL} kind_t;

    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_ADDU = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_SUBU = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] OP_MUL  = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] OP_NOP  = ALUOP_W'(15);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int MD_W  = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(MEM_TIMEOUT);
    localparam logic [MD_W-1:0]  MD_INIT = MD_W'(MULDIV_LAT - 1);
    localparam logic             MD_EN   = (ENABLE_MULDIV != 0);

    state_t             r_state;
    kind_t              r_kind;
    logic [ALUOP_W-1:0] r_alu_op;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [MD_W-1:0]    r_md_cnt;

    state_t             w_next;
    kind_t              w_kind;
    logic [ALUOP_W-1:0] w_alu;
    logic               w_waiting;
    logic               w_imem_req;

    // Instruction decode from the IR fields; only consumed during DECODE.
    always_comb begin
        w_kind = K_ILL;
        w_alu  = OP_NOP;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin w_kind = K_RALU;  w_alu = OP_ADD;  end
                    6'h21: begin w_kind = K_RALU;  w_alu = OP_ADDU; end
                    6'h22: begin w_kind = K_RALU;  w_alu = OP_SUB;  end
                    6'h23: begin w_kind = K_RALU;  w_alu = OP_SUBU; end
                    6'h24: begin w_kind = K_RALU;  w_alu = OP_AND;  end
                    6'h25: begin w_kind = K_RALU;  w_alu = OP_OR;   end
                    6'h26: begin w_kind = K_RALU;  w_alu = OP_XOR;  end
                    6'h00: begin w_kind = K_SHIFT; w_alu = OP_SLL;  end
                    6'h02: begin w_kind = K_SHIFT; w_alu = OP_SRL;  end
                    6'h03: begin w_kind = K_SHIFT; w_alu = OP_SRA;  end
                    6'h2A: begin w_kind = K_RALU;  w_alu = OP_SLT;  end
                    6'h2B: begin w_kind = K_RALU;  w_alu = OP_SLTU; end
                    6'h18: if (MD_EN) begin w_kind = K_MULDIV; w_alu = OP_MUL; end
                    6'h1A: if (MD_EN) begin w_kind = K_MULDIV; w_alu = OP_DIV; end
                    default: ;
                endcase
            end
            6'h08: begin w_kind = K_IMM; w_alu = OP_ADD;  end
            6'h09: begin w_kind = K_IMM; w_alu = OP_ADDU; end
            6'h0C: begin w_kind = K_IMM; w_alu = OP_AND;  end
            6'h0D: begin w_kind = K_IMM; w_alu = OP_OR;   end
            6'h0E: begin w_kind = K_IMM; w_alu = OP_XOR;  end
            6'h0A: begin w_kind = K_IMM; w_alu = OP_SLT;  end
            6'h0B: begin w_kind = K_IMM; w_alu = OP_SLTU; end
            6'h23: begin w_kind = K_LW;  w_alu = OP_ADD;  end
            6'h2B: begin w_kind = K_SW;  w_alu = OP_ADD;  end
            6'h04: begin w_kind = K_BEQ; w_alu = OP_SUB;  end
            6'h02: begin w_kind = K_J;   w_alu = OP_NOP;  end
            default: ;
        endcase
    end

    // State register, memory wait counter, mul/div down-counter and latched decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_kind     <= K_ILL;
            r_alu_op   <= OP_NOP;
            r_wait_cnt <= '0;
            r_md_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Any cycle that is not a missing-ready wait clears the counter, so it
            // is always zero on entry to FETCH or MEM.
            if (w_waiting) r_wait_cnt <= r_wait_cnt + 1'b1;
            else           r_wait_cnt <= '0;
            if (r_state == S_DECODE) begin
                r_kind   <= w_kind;
                r_alu_op <= w_alu;
                r_md_cnt <= MD_INIT;
            end else if (r_state == S_EXEC && r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - 1'b1;
            end
        end
    end

    // Next-state and strobe generation; a wait counter at TMO is the bus-error cycle.
    always_comb begin
        w_next     = r_state;
        w_waiting  = 1'b0;
        w_imem_req = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_start  = 1'b0;
        alu_src_b  = 2'd0;
        pc_src     = 2'd0;
        alu_op     = OP_NOP;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_wait_cnt == TMO) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    w_imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                        w_next   = S_DECODE;
                    end else begin
                        w_waiting = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                alu_op = w_alu;
                if (w_kind == K_ILL) begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end else if (w_kind == K_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = r_alu_op;
                case (r_kind)
                    K_SHIFT: begin alu_src_b = 2'd2; w_next = S_WB; end
                    K_IMM:   begin alu_src_b = 2'd1; w_next = S_WB; end
                    K_LW, K_SW: begin alu_src_b = 2'd1; w_next = S_MEM; end
                    K_BEQ: begin
                        pc_write = alu_zero;
                        pc_src   = 2'd1;
                        w_next   = S_FETCH;
                    end
                    K_MULDIV: begin
                        alu_start = (r_md_cnt == MD_INIT);
                        w_next    = (r_md_cnt == '0) ? S_WB : S_EXEC;
                    end
                    default: w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (r_wait_cnt == TMO) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    dmem_req = 1'b1;
                    dmem_we  = (r_kind == K_SW);
                    if (dmem_ready) w_next = (r_kind == K_LW) ? S_WB : S_FETCH;
                    else            w_waiting = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (r_kind == K_RALU) || (r_kind == K_SHIFT) || (r_kind == K_MULDIV);
                mem_to_reg = (r_kind == K_LW);
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // FETCH is the reset state, so gate its request while reset is held.
    assign imem_req = w_imem_req & reset_n;
    assign state    = r_state;
    assign busy     = (r_state != S_FETCH);
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       alu_zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;

    logic imem_req, dmem_req, dmem_we, ir_load, pc_write, reg_write, reg_dst, mem_to_reg, alu_start;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_op;
    logic [2:0] state;
    logic illegal, bus_err, busy;

    logic b_imem_req, b_dmem_req, b_dmem_we, b_ir_load, b_pc_write, b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_start;
    logic [1:0] b_alu_src_b, b_pc_src;
    logic [3:0] b_alu_op;
    logic [2:0] b_state;
    logic b_illegal, b_bus_err, b_busy;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    multicycle_control #(.ALUOP_W(4), .MULDIV_LAT(4), .ENABLE_MULDIV(1), .MEM_TIMEOUT(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_start(alu_start), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_op(alu_op), .state(state), .illegal(illegal), .bus_err(bus_err), .busy(busy)
    );

    multicycle_control #(.ALUOP_W(4), .MULDIV_LAT(4), .ENABLE_MULDIV(0), .MEM_TIMEOUT(16)) u_nomd (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(b_imem_req), .dmem_req(b_dmem_req),
        .dmem_we(b_dmem_we), .ir_load(b_ir_load), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .alu_start(b_alu_start), .alu_src_b(b_alu_src_b),
        .pc_src(b_pc_src), .alu_op(b_alu_op), .state(b_state), .illegal(b_illegal), .bus_err(b_bus_err), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int st;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_strobes", {imem_req, dmem_req, ir_load, pc_write, reg_write, busy, illegal, bus_err}, 8'h00);
        chk("rst_alu_op_src", {alu_op, alu_src_b, pc_src}, {4'd15, 2'd0, 2'd0});

        // ADD: FETCH, DECODE, EXEC, WB
        @(negedge clk); reset_n = 1'b1; opcode = 6'h00; funct = 6'h20; imem_ready = 1'b1; #1;
        t0 = cyc_n;
        chk("add_fetch", {state, imem_req, ir_load, pc_write, pc_src, busy}, {3'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0});
        @(negedge clk); #1;
        chk("add_decode", {state, busy, imem_req, ir_load, pc_write}, {3'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk); #1;
        chk("add_exec", {state, alu_op, alu_src_b, reg_write}, {3'd2, 4'd0, 2'd0, 1'b0});
        @(negedge clk); #1;
        chk("add_wb", {state, reg_write, reg_dst, mem_to_reg, alu_op}, {3'd4, 1'b1, 1'b1, 1'b0, 4'd15});
        @(negedge clk); funct = 6'h00; #1;
        chk("add_total", {state, 8'(cyc_n - t0)}, {3'd0, 8'd4});

        // SLL: shamt operand
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("sll_exec", {state, alu_op, alu_src_b}, {3'd2, 4'd7, 2'd2});
        @(negedge clk); opcode = 6'h08; #1;
        chk("sll_wb", {state, reg_write, reg_dst}, {3'd4, 1'b1, 1'b1});

        // ADDI: immediate operand, rt destination
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("addi_exec", {state, alu_op, alu_src_b}, {3'd2, 4'd0, 2'd1});
        @(negedge clk); opcode = 6'h23; #1;
        chk("addi_wb", {state, reg_write, reg_dst, mem_to_reg}, {3'd4, 1'b1, 1'b0, 1'b0});

        // LW with dmem_ready on the 4th MEM cycle
        @(negedge clk); #1;
        t0 = cyc_n;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("lw_exec", {state, alu_op, alu_src_b}, {3'd2, 4'd0, 2'd1});
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dmem_ready = (i == 3); #1;
            if (state == 3'd3 && dmem_req && !dmem_we && busy) n++;
        end
        chk("lw_mem_cycles", n, 4);
        @(negedge clk); dmem_ready = 1'b0; #1;
        chk("lw_wb", {state, reg_write, reg_dst, mem_to_reg, dmem_req}, {3'd4, 1'b1, 1'b0, 1'b1, 1'b0});
        @(negedge clk); opcode = 6'h04; alu_zero = 1'b1; #1;
        chk("lw_total", {state, 8'(cyc_n - t0)}, {3'd0, 8'd8});

        // BEQ taken
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("beq_taken_exec", {state, alu_op, alu_src_b, pc_write, pc_src, reg_write}, {3'd2, 4'd2, 2'd0, 1'b1, 2'd1, 1'b0});
        @(negedge clk); alu_zero = 1'b0; #1;
        chk("beq_taken_next", {state, reg_write}, {3'd0, 1'b0});

        // BEQ not taken
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("beq_nt_exec", {state, pc_write, pc_src, reg_write}, {3'd2, 1'b0, 2'd1, 1'b0});
        @(negedge clk); opcode = 6'h02; #1;

        // J
        @(negedge clk); #1;
        chk("j_decode", {state, pc_write, pc_src, illegal}, {3'd1, 1'b1, 2'd2, 1'b0});
        @(negedge clk); opcode = 6'h00; funct = 6'h18; #1;
        chk("j_next", state, 3'd0);

        // MUL: legal in u_dut, illegal in u_nomd
        @(negedge clk); #1;
        chk("mul_decode", {state, illegal}, {3'd1, 1'b0});
        chk("nomd_illegal", {b_state, b_illegal, b_reg_write}, {3'd1, 1'b1, 1'b0});
        n = 0; st = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (state == 3'd2 && alu_op == 4'd12) n++;
            if (alu_start) st++;
            if (i == 0) chk("mul_start_first", alu_start, 1'b1);
        end
        chk("mul_exec_cycles", n, 4);
        chk("mul_start_pulses", st, 1);
        @(negedge clk); opcode = 6'h3F; #1;
        chk("mul_wb", {state, reg_write, reg_dst}, {3'd4, 1'b1, 1'b1});

        // Illegal opcode
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("ill_decode", {state, illegal, reg_write, pc_write, dmem_req}, {3'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk); opcode = 6'h2B; #1;
        chk("ill_next", {state, illegal}, {3'd0, 1'b0});

        // SW interrupted by reset in MEM
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("sw_mem", {state, dmem_req, dmem_we}, {3'd3, 1'b1, 1'b1});
        #2 reset_n = 1'b0;
        #1;
        chk("sw_async_rst", {state, dmem_req, dmem_we, busy, imem_req}, {3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk); @(negedge clk); reset_n = 1'b1; imem_ready = 1'b0; #1;
        chk("rst_restart", {state, imem_req}, {3'd0, 1'b1});

        // Instruction fetch timeout
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus_err) break;
            if (imem_req) n++;
        end
        chk("tmo_req_cycles", n, 16);
        chk("tmo_bus_err", {bus_err, imem_req, pc_write, ir_load, state}, {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        @(negedge clk); #1;
        chk("tmo_refetch", {bus_err, imem_req, state}, {1'b0, 1'b1, 3'd0});

        // Ready on the last allowed cycle is a successful fetch
        for (int i = 0; i < 14; i++) @(negedge clk);
        @(negedge clk); imem_ready = 1'b1; #1;
        chk("tmo_edge_ok", {imem_req, ir_load, pc_write, bus_err}, {1'b1, 1'b1, 1'b1, 1'b0});
        @(negedge clk); imem_ready = 1'b0; #1;
        chk("tmo_edge_decode", {state, bus_err}, {3'd1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface -- parameters
REQ-001 SHALL: ALUOP_W, 4, width of alu_op (>=4).
REQ-002 SHALL: MULDIV_LAT, 4, EXEC cycles for mult/div (>=1).
REQ-003 SHALL: ENABLE_MULDIV, 1, 0 makes mult/div illegal.
REQ-004 SHALL: MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready (>=2).

Interface -- ports
REQ-005 SHALL: clk  in  1  single clock, rising edge.
REQ-006 SHALL: reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL: opcode  in  6; funct  in  6  from the instruction register.
REQ-008 SHALL: alu_zero  in  1; imem_ready  in  1; dmem_ready  in  1.
REQ-009 SHALL: imem_req, dmem_req, dmem_we, ir_load, pc_write, reg_write, reg_dst, mem_to_reg, alu_start  out  1.
REQ-010 SHALL: alu_src_b  out  2 (0 = rt, 1 = sign-ext imm, 2 = shamt); pc_src  out  2 (0 = pc+4, 1 = branch target, 2 = jump target).
REQ-011 SHALL: alu_op  out  ALUOP_W; state  out  3; illegal  out  1; bus_err  out  1; busy  out  1.

Function
REQ-012 SHALL: alu_op codes are ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, SLL 7, SRL 8, SRA 9, SLT 10, SLTU 11, MUL 12, DIV 13, NOP 15.
REQ-013 SHALL: states are FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, registered and presented on state.
REQ-014 SHALL: decode R-type (op 0x00) funct 0x20/21/22/23/24/25/26/00/02/03/2A/2B -> ADD/ADDU/SUB/SUBU/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU, 0x18 -> MUL, 0x1A -> DIV.
REQ-015 SHALL: decode I/J opcodes 0x08 ADDI, 0x09 ADDIU, 0x0C ANDI, 0x0D ORI, 0x0E XORI, 0x0A SLTI, 0x0B SLTIU, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J; all others illegal.
REQ-016 SHALL: FETCH holds imem_req=1 until imem_ready; on that edge pulse ir_load and pc_write (pc_src=0) for one cycle and go to DECODE.
REQ-017 SHALL: DECODE lasts exactly one cycle; illegal -> pulse illegal one cycle, return to FETCH with no register or memory write; J -> pc_write=1, pc_src=2, go to FETCH; else -> EXEC.
REQ-018 SHALL: EXEC for non-muldiv lasts one cycle; shifts use alu_src_b=2, immediates and LW/SW use 1 with alu_op ADD, R-type uses 0.
REQ-019 SHALL: EXEC for MUL/DIV pulses alu_start on first EXEC cycle and stays MULDIV_LAT cycles via down-counter, then WB.
REQ-020 SHALL: BEQ in EXEC uses alu_op SUB, alu_src_b=0; pc_write=alu_zero, pc_src=1; next FETCH; reg_write never asserted.
REQ-021 SHALL: LW/SW go EXEC -> MEM; MEM holds dmem_req=1 (dmem_we=1 for SW) until dmem_ready; LW -> WB, SW -> FETCH.
REQ-022 SHALL: WB pulses reg_write one cycle; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 only for LW; next FETCH.
REQ-023 SHALL: wait counter clears on entering FETCH/MEM; if ready absent for MEM_TIMEOUT consecutive cycles, drop req, pulse bus_err one cycle, go to FETCH (no pc_write, no reg_write).
REQ-024 SHALL: ready arriving on the same cycle the counter reaches MEM_TIMEOUT counts as success, not bus_err.
REQ-025 SHALL: ready inputs are ignored outside the matching state.
REQ-026 SHALL: busy=1 in every state except FETCH; all strobes not named active in a state are 0; alu_op=NOP outside DECODE/EXEC.

Reset
REQ-027 SHALL: reset_n=0 asynchronously forces state=FETCH, counters=0, all 1-bit outputs 0, alu_op=NOP, alu_src_b=0, pc_src=0, including mid-EXEC or mid-MEM.
REQ-028 SHALL: first imem_req asserts in the first cycle after reset_n deasserts.

Verification
REQ-029 SHALL: op 0x00 funct 0x20, imem_ready=1 -> FETCH,DECODE,EXEC(alu_op 0),WB(reg_write=1, reg_dst=1) = 4 cycles.
REQ-030 SHALL: LW 0x23, dmem_ready after 3 cycles -> MEM dmem_req 4 cycles, WB mem_to_reg=1, total 8 cycles.
REQ-031 SHALL: BEQ 0x04, alu_zero=1 -> EXEC pc_write=1, pc_src=1; with alu_zero=0 -> pc_write=0.
REQ-032 SHALL: MUL (funct 0x18), MULDIV_LAT=4 -> alu_start single pulse, EXEC 4 cycles; ENABLE_MULDIV=0 -> illegal pulse in DECODE.
REQ-033 SHALL: imem_ready held 0, MEM_TIMEOUT=16 -> bus_err pulse after 16 cycles, FETCH re-entered, imem_req reasserts.
REQ-034 SHALL: reset_n low during MEM of SW -> dmem_req, dmem_we fall without clock edge; restart in FETCH.
